weighted_rr_arbiter: RTL and testbench
======================================

# weighted_rr_arbiter

- Grants a shared resource among 4 requesters with weighted round-robin.
- Each requester holds a one-hot grant for up to `weight[i]` consecutive cycles.
- The grant moves on when that credit is spent or the owner drops its request.
- It replaces the plain one-grant-per-cycle round-robin arbiter in front of shared buses and memory ports where burst transfers must not be split.

## Interface
Parameters:
- `N` — 4 — number of requesters.
- `WW` — 4 — weight and credit width; maximum weight is 2^WW−1.
- `DEF_WEIGHT` — 1 — weight loaded into every slot at reset. A value of 1 gives plain round-robin.

Ports:
- `clk` — in — 1 — single clock.
- `rst_n` — in — 1 — reset, asynchronous, active-low.
- `REQ` — in — N — request vector, level-sensitive, sampled on posedge `clk`.
- `GNT` — out — N — registered one-hot grant, or all-zero.
- `gnt_id` — out — $clog2(N) — index of the current owner. Valid only while `busy`=1; holds its last value otherwise.
- `busy` — out — 1 — 1 while some requester is granted.
- `credit` — out — WW — remaining cycles in the current tenure, including the present one.
- `cfg_wr` — in — 1 — write strobe for the weight table.
- `cfg_idx` — in — $clog2(N) — weight slot to write.
- `cfg_weight` — in — WW — new weight. 0 disables the requester.

## Operation
- State machine with two states, IDLE and GRANT.
- **Eligibility:** `elig = REQ & (weight != 0)`, evaluated per bit.
- **Rotating pick:** search `elig` starting at index `ptr`, wrapping modulo N. The first set bit wins.
- **IDLE:**
  - `elig` = 0: stay in IDLE.
  - Otherwise: winner `w` → go to GRANT, set `GNT=onehot(w)`, `gnt_id=w`, `credit=weight[w]`.
- **GRANT, owner `o`:** at each posedge, evaluate:
  - `REQ[o]`=1 and `credit`>1 → `credit`−1, grant held.
  - `REQ[o]`=1 and `credit`==1 → tenure ends; this last beat is counted.
  - `REQ[o]`=0 → tenure ends; the cycle is not counted.
- **Tenure end, same edge:**
  - Set `ptr <= (o+1) mod N`.
  - Re-pick from `elig` starting at the new `ptr`. Requester `o` is therefore lowest priority but still eligible.
  - If there is a winner, load its grant and credit with no idle bubble. This includes `o` re-granting itself with a reloaded credit.
  - If there is none, go to IDLE with `GNT`=0.
- **Weight writes:**
  - When `cfg_wr`=1, `weight[cfg_idx] <= cfg_weight` at the posedge.
  - The new weight applies from the next credit load only. The running `credit` is never modified.
  - A write of 0 to the current owner does not revoke the grant. The owner keeps its grant until the tenure ends.
  - A write in the same cycle as a tenure end uses the old weight for the load performed on that edge.
- **Invariant:** `GNT` is always zero or one-hot, and `GNT[gnt_id]`==`busy`.

## Timing
- **Reset values:** `GNT`=0, `gnt_id`=0, `busy`=0, `credit`=0, `ptr`=0, state IDLE, all weights=`DEF_WEIGHT`.
- **Reset assertion:** asynchronous. Outputs clear immediately, including in the middle of a tenure. Release is synchronous to `clk`.
- **Latency:** from `REQ` set in IDLE to `GNT` high is 1 cycle (registered).
- **Tenure length:** a tenure with continuously held `REQ` lasts exactly `weight` cycles.
- **Request drop:** after the owner drops `REQ`, `GNT` stays high for 1 more cycle. That cycle is uncounted. The next owner's grant appears on the same edge that ends the tenure.
- **Non-owner requests:** changes on `REQ` of non-owners during a tenure have no effect until the tenure-end edge.
- **Outputs:** purely registered; no combinational path from `REQ` to `GNT`.
- **Credit range:** `credit` never underflows. Range is 1..weight in GRANT and 0 in IDLE.

## Structure
- Package `wrr_arb_pkg` holds:
  - default constants `N`, `WW` and `IDW=$clog2(N)`;
  - state enum `{ARB_IDLE, ARB_GRANT}`;
  - function `onehot(idx)`.
- One combinational sub-module, `rr_pick`:
  - inputs: `elig[N-1:0]`, `ptr[IDW-1:0]`;
  - outputs: `found`, `idx[IDW-1:0]`.
- The top level holds the weight table, `ptr`, credit counter, state register and output registers.

## Test plan
- **Plain round-robin:** reset defaults, `REQ`=4'b1111 held → `GNT` sequence 0001, 0010, 0100, 1000, 0001, one cycle each, `busy` always 1.
- **Weighted tenures:** write weight[0]=3 and weight[2]=2, then hold `REQ`=4'b0101 → `GNT` 0001 ×3 (`credit` 3,2,1), then 0100 ×2, then 0001 ×3, with no bubbles.
- **Early release:** weight[1]=4, `REQ`=4'b0010 for 2 granted cycles, then `REQ`=4'b1000 → `GNT` 0010 ×3 (the third cycle is uncounted), then 1000 with `credit`=1.
- **Masking and self re-grant:**
  - Write weight[3]=0, then `REQ`=4'b1000 → `GNT` stays 0000, `busy`=0.
  - Write weight[3]=2 → after 1 cycle `GNT`=1000 continuously, with `credit` alternating 2,1,2,1.
- **Reset mid-tenure:** `GNT`=0100 with `credit`=2, then `rst_n`=0 between edges → `GNT`=0 immediately. After release, `REQ`=4'b1111 → first `GNT`=0001 with weights back to 1.
- **Config during tenure:** owner 0 with weight 3 at `credit`=2, write weight[0]=1 → tenure completes with `credit` 2,1. The next grant to 0 loads `credit`=1.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
// Shared constants, state encoding and helpers for the weighted round-robin arbiter.
package wrr_arb_pkg;

    localparam int unsigned N   = 4;
    localparam int unsigned WW  = 4;
    localparam int unsigned IDW = $clog2(N);

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_e;

    function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority pick: first set bit of elig at or after ptr, wrapping modulo N.
module rr_pick
    import wrr_arb_pkg::*;
#(
    parameter int unsigned N   = wrr_arb_pkg::N,
    parameter int unsigned IDW = $clog2(N)
) (
    input  logic [N-1:0]   elig,
    input  logic [IDW-1:0] ptr,
    output logic           found,
    output logic [IDW-1:0] idx
);

    int unsigned j;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr) + k) % N;
            if (!found && elig[j]) begin
                found = 1'b1;
                idx   = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: each owner keeps a one-hot grant for up to
// weight[i] consecutive cycles, or until it drops its request.
module weighted_rr_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int unsigned N          = wrr_arb_pkg::N,
    parameter int unsigned WW         = wrr_arb_pkg::WW,
    parameter int unsigned DEF_WEIGHT = 1,
    localparam int unsigned IDW       = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   REQ,
    output logic [N-1:0]   GNT,
    output logic [IDW-1:0] gnt_id,
    output logic           busy,
    output logic [WW-1:0]  credit,
    input  logic           cfg_wr,
    input  logic [IDW-1:0] cfg_idx,
    input  logic [WW-1:0]  cfg_weight
);

    arb_state_e     state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [WW-1:0]  credit_q, credit_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic [IDW-1:0] gnt_id_q, gnt_id_d;
    logic [WW-1:0]  weight_q [N];

    logic [N-1:0]   elig;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] pick_ptr;
    logic           pick_found;
    logic [IDW-1:0] pick_idx;
    logic           tenure_end;

    always_comb begin
        elig = '0;
        for (int unsigned i = 0; i < N; i++) begin
            elig[i] = REQ[i] && (weight_q[i] != '0);
        end
    end

    // At tenure end the search restarts just past the outgoing owner.
    assign next_ptr   = (gnt_id_q == IDW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
    assign pick_ptr   = (state_q == ARB_GRANT) ? next_ptr : ptr_q;
    assign tenure_end = (state_q == ARB_GRANT) &&
                        (!REQ[gnt_id_q] || (credit_q == WW'(1)));

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_rr_pick (
        .elig  (elig),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        credit_d = credit_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d  = ARB_GRANT;
                    gnt_d    = N'(onehot(pick_idx));
                    gnt_id_d = pick_idx;
                    credit_d = weight_q[pick_idx];
                end
            end
            ARB_GRANT: begin
                if (tenure_end) begin
                    ptr_d = next_ptr;
                    // weight_q still holds the pre-write value on a same-edge cfg write.
                    if (pick_found) begin
                        gnt_d    = N'(onehot(pick_idx));
                        gnt_id_d = pick_idx;
                        credit_d = weight_q[pick_idx];
                    end else begin
                        state_d  = ARB_IDLE;
                        gnt_d    = '0;
                        credit_d = '0;
                    end
                end else begin
                    credit_d = credit_q - 1'b1;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB_IDLE;
            ptr_q    <= '0;
            credit_q <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            credit_q <= credit_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N; i++) begin
                weight_q[i] <= WW'(DEF_WEIGHT);
            end
        end else if (cfg_wr) begin
            weight_q[cfg_idx] <= cfg_weight;
        end
    end

    assign GNT    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign busy   = (state_q == ARB_GRANT);
    assign credit = credit_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// Directed self-checking bench for weighted_rr_arbiter.
module tb_weighted_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic [1:0] gnt_id;
    logic       busy;
    logic [3:0] credit;
    logic       cfg_wr;
    logic [1:0] cfg_idx;
    logic [3:0] cfg_weight;

    int errors = 0;
    int checks = 0;

    weighted_rr_arbiter #(
        .N          (4),
        .WW         (4),
        .DEF_WEIGHT (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .REQ        (REQ),
        .GNT        (GNT),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .credit     (credit),
        .cfg_wr     (cfg_wr),
        .cfg_idx    (cfg_idx),
        .cfg_weight (cfg_weight)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        REQ    = 4'b0000;
        cfg_wr = 1'b0;
        cfg_idx = 2'd0;
        cfg_weight = 4'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic write_weight(input logic [1:0] idx, input logic [3:0] w);
        cfg_wr     = 1'b1;
        cfg_idx    = idx;
        cfg_weight = w;
        tick();
        cfg_wr     = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        REQ = 4'b1111;
        cfg_wr = 1'b0;
        cfg_idx = 2'd0;
        cfg_weight = 4'd0;
        #3;
        checks++;
        if (GNT !== 4'b0000) begin
            errors++; $display("FAIL reset_gnt: got %b want 0000", GNT);
        end
        checks++;
        if (gnt_id !== 2'd0) begin
            errors++; $display("FAIL reset_gnt_id: got %0d want 0", gnt_id);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        checks++;
        if (credit !== 4'd0) begin
            errors++; $display("FAIL reset_credit: got %0d want 0", credit);
        end
        do_reset();
    endtask

    task automatic test_plain_rr();
        logic [3:0] exp_g [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        REQ = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (GNT !== exp_g[i] || busy !== 1'b1 || credit !== 4'd1) begin
                errors++;
                $display("FAIL plain_rr[%0d]: got gnt=%b busy=%b credit=%0d want gnt=%b busy=1 credit=1",
                         i, GNT, busy, credit, exp_g[i]);
            end
        end
        REQ = 4'b0000;
        tick();
        checks++;
        if (GNT !== 4'b0000 || busy !== 1'b0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL plain_rr_idle: got gnt=%b busy=%b credit=%0d want 0000/0/0",
                     GNT, busy, credit);
        end
    endtask

    task automatic test_weighted();
        logic [3:0] exp_g [8];
        logic [3:0] exp_c [8];
        exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0100, 4'b0001, 4'b0001, 4'b0001};
        exp_c = '{4'd3, 4'd2, 4'd1, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1};
        do_reset();
        write_weight(2'd0, 4'd3);
        write_weight(2'd2, 4'd2);
        REQ = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (GNT !== exp_g[i] || credit !== exp_c[i]) begin
                errors++;
                $display("FAIL weighted[%0d]: got gnt=%b credit=%0d want gnt=%b credit=%0d",
                         i, GNT, credit, exp_g[i], exp_c[i]);
            end
        end
    endtask

    task automatic test_early_release();
        logic [3:0] exp_c [3];
        exp_c = '{4'd4, 4'd3, 4'd2};
        do_reset();
        write_weight(2'd1, 4'd4);
        REQ = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 2) REQ = 4'b1000;
            checks++;
            if (GNT !== 4'b0010 || credit !== exp_c[i] || gnt_id !== 2'd1) begin
                errors++;
                $display("FAIL early_rel[%0d]: got gnt=%b id=%0d credit=%0d want 0010/1/%0d",
                         i, GNT, gnt_id, credit, exp_c[i]);
            end
        end
        tick();
        checks++;
        if (GNT !== 4'b1000 || credit !== 4'd1 || gnt_id !== 2'd3 || busy !== 1'b1) begin
            errors++;
            $display("FAIL early_rel_next: got gnt=%b id=%0d credit=%0d busy=%b want 1000/3/1/1",
                     GNT, gnt_id, credit, busy);
        end
    endtask

    task automatic test_mask_regrant();
        logic [3:0] exp_c [4];
        exp_c = '{4'd2, 4'd1, 4'd2, 4'd1};
        do_reset();
        write_weight(2'd3, 4'd0);
        REQ = 4'b1000;
        tick();
        tick();
        checks++;
        if (GNT !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL masked: got gnt=%b busy=%b want 0000/0", GNT, busy);
        end
        write_weight(2'd3, 4'd2);
        checks++;
        if (GNT !== 4'b0000) begin
            errors++;
            $display("FAIL mask_write_edge: got gnt=%b want 0000", GNT);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (GNT !== 4'b1000 || credit !== exp_c[i]) begin
                errors++;
                $display("FAIL self_regrant[%0d]: got gnt=%b credit=%0d want 1000/%0d",
                         i, GNT, credit, exp_c[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_g [3];
        exp_g = '{4'b0001, 4'b0010, 4'b0100};
        do_reset();
        write_weight(2'd2, 4'd3);
        REQ = 4'b0100;
        tick();
        tick();
        checks++;
        if (GNT !== 4'b0100 || credit !== 4'd2) begin
            errors++;
            $display("FAIL mid_setup: got gnt=%b credit=%0d want 0100/2", GNT, credit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (GNT !== 4'b0000 || busy !== 1'b0 || credit !== 4'd0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL async_reset: got gnt=%b busy=%b credit=%0d id=%0d want 0000/0/0/0",
                     GNT, busy, credit, gnt_id);
        end
        tick();
        rst_n = 1'b1;
        REQ = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (GNT !== exp_g[i] || credit !== 4'd1) begin
                errors++;
                $display("FAIL post_reset[%0d]: got gnt=%b credit=%0d want %b/1",
                         i, GNT, credit, exp_g[i]);
            end
        end
    endtask

    task automatic test_config_during();
        do_reset();
        write_weight(2'd0, 4'd3);
        REQ = 4'b0001;
        tick();
        tick();
        checks++;
        if (GNT !== 4'b0001 || credit !== 4'd2) begin
            errors++;
            $display("FAIL cfg_setup: got gnt=%b credit=%0d want 0001/2", GNT, credit);
        end
        write_weight(2'd0, 4'd1);
        checks++;
        if (GNT !== 4'b0001 || credit !== 4'd1) begin
            errors++;
            $display("FAIL cfg_running: got gnt=%b credit=%0d want 0001/1", GNT, credit);
        end
        tick();
        checks++;
        if (GNT !== 4'b0001 || credit !== 4'd1) begin
            errors++;
            $display("FAIL cfg_reload: got gnt=%b credit=%0d want 0001/1", GNT, credit);
        end
        // Write on a tenure-end edge: reload uses the old weight (1), next one the new (3).
        write_weight(2'd0, 4'd3);
        checks++;
        if (GNT !== 4'b0001 || credit !== 4'd1) begin
            errors++;
            $display("FAIL cfg_same_edge: got gnt=%b credit=%0d want 0001/1", GNT, credit);
        end
        tick();
        checks++;
        if (GNT !== 4'b0001 || credit !== 4'd3) begin
            errors++;
            $display("FAIL cfg_new_weight: got gnt=%b credit=%0d want 0001/3", GNT, credit);
        end
        // Disabling the owner mid-tenure lets the tenure finish, then goes idle.
        write_weight(2'd0, 4'd0);
        checks++;
        if (GNT !== 4'b0001 || credit !== 4'd2) begin
            errors++;
            $display("FAIL cfg_zero_kept: got gnt=%b credit=%0d want 0001/2", GNT, credit);
        end
        tick();
        tick();
        checks++;
        if (GNT !== 4'b0000 || busy !== 1'b0 || credit !== 4'd0) begin
            errors++;
            $display("FAIL cfg_zero_idle: got gnt=%b busy=%b credit=%0d want 0000/0/0",
                     GNT, busy, credit);
        end
    endtask

    initial begin
        test_reset();
        test_plain_rr();
        test_weighted();
        test_early_release();
        test_mask_regrant();
        test_reset_mid();
        test_config_during();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
